// File: rtl/fb_fill_engine_if.sv
// Command and framebuffer-write bundle between a command source and fb_fill_engine.
// master = command source and framebuffer side, slave = the engine.
interface fb_fill_engine_if #(
  parameter int FB_ADDRESS_WIDTH  = 15,
  parameter int COLOR_INDEX_WIDTH = 8
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [7:0]                   cmd_x;
  logic [7:0]                   cmd_y;
  logic [7:0]                   cmd_w;
  logic [7:0]                   cmd_h;
  logic [COLOR_INDEX_WIDTH-1:0] cmd_color;
  logic                         fb_stall;
  logic                         write_fb;
  logic [FB_ADDRESS_WIDTH-1:0]  fb_address_write;
  logic [COLOR_INDEX_WIDTH-1:0] fb_data_in;
  logic                         busy;
  logic                         done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_stall,
    input  cmd_ready, write_fb, fb_address_write, fb_data_in, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_stall,
    output cmd_ready, write_fb, fb_address_write, fb_data_in, busy, done
  );
endinterface

// File: rtl/fb_fill_engine.sv
// Turns plot / rect / clear commands into a clipped, row-major stream of
// single-pixel framebuffer writes, one pixel per unstalled cycle.
//
// state | meaning
// IDLE  | ready for a command, latches cmd_* on cmd_valid
// SETUP | resolve op, clip against the framebuffer, load row/col walkers
// DRAW  | one write per cycle while fb_stall is low
// DONE  | one-cycle done pulse, then back to IDLE
module fb_fill_engine #(
  parameter int FB_WIDTH          = 160,
  parameter int FB_HEIGHT         = 120,
  parameter int FB_ADDRESS_WIDTH  = $clog2(FB_WIDTH*FB_HEIGHT),
  parameter int COLOR_INDEX_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  fb_fill_engine_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  localparam logic [1:0] OP_PLOT  = 2'd0;
  localparam logic [1:0] OP_RECT  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  localparam logic [8:0] WIDTH_9  = 9'(FB_WIDTH);
  localparam logic [8:0] HEIGHT_9 = 9'(FB_HEIGHT);
  localparam logic [FB_ADDRESS_WIDTH-1:0] ROW_STEP = FB_ADDRESS_WIDTH'(FB_WIDTH);

  state_t                       state;
  logic [1:0]                   op_q;
  logic [7:0]                   x_q, y_q, w_q, h_q;
  logic [COLOR_INDEX_WIDTH-1:0] color_q;
  logic [7:0]                   col, row, x_first, x_last, y_last;
  logic [FB_ADDRESS_WIDTH-1:0]  row_base, addr;
  logic [COLOR_INDEX_WIDTH-1:0] data;
  logic                         cmd_ready_q, busy_q, done_q;

  logic [7:0]                   eff_x, eff_y, eff_w, eff_h;
  logic                         op_empty, rect_empty;
  logic [8:0]                   x_sum, y_sum, x_end, y_end;
  logic [7:0]                   x_last_c, y_last_c;
  logic [FB_ADDRESS_WIDTH-1:0]  y_wide, base;

  always_comb begin
    eff_x    = x_q;
    eff_y    = y_q;
    eff_w    = w_q;
    eff_h    = h_q;
    op_empty = 1'b0;
    case (op_q)
      OP_PLOT: begin
        eff_w = 8'd1;
        eff_h = 8'd1;
      end
      OP_RECT: begin
        eff_w = w_q;
      end
      OP_CLEAR: begin
        eff_x = 8'd0;
        eff_y = 8'd0;
        eff_w = 8'(FB_WIDTH);
        eff_h = 8'(FB_HEIGHT);
      end
      default: op_empty = 1'b1;
    endcase
    x_sum      = {1'b0, eff_x} + {1'b0, eff_w};
    y_sum      = {1'b0, eff_y} + {1'b0, eff_h};
    x_end      = (x_sum > WIDTH_9)  ? WIDTH_9  : x_sum;
    y_end      = (y_sum > HEIGHT_9) ? HEIGHT_9 : y_sum;
    x_last_c   = 8'(x_end - 9'd1);
    y_last_c   = 8'(y_end - 9'd1);
    rect_empty = op_empty || ({1'b0, eff_x} >= WIDTH_9) || ({1'b0, eff_y} >= HEIGHT_9) ||
                 (eff_w == 8'd0) || (eff_h == 8'd0);
    // y*160 as two shifts so no multiplier is inferred
    y_wide     = FB_ADDRESS_WIDTH'(eff_y);
    base       = (y_wide << 7) + (y_wide << 5);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      col         <= '0;
      row         <= '0;
      x_first     <= '0;
      x_last      <= '0;
      y_last      <= '0;
      row_base    <= '0;
      addr        <= '0;
      data        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            x_q         <= bus.cmd_x;
            y_q         <= bus.cmd_y;
            w_q         <= bus.cmd_w;
            h_q         <= bus.cmd_h;
            color_q     <= bus.cmd_color;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          data <= color_q;
          if (rect_empty) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            col      <= eff_x;
            x_first  <= eff_x;
            x_last   <= x_last_c;
            row      <= eff_y;
            y_last   <= y_last_c;
            row_base <= base;
            addr     <= base + FB_ADDRESS_WIDTH'(eff_x);
            state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (!bus.fb_stall) begin
            if (col == x_last) begin
              // address is left on the last pixel so it never leaves the framebuffer
              if (row == y_last) begin
                done_q <= 1'b1;
                state  <= S_DONE;
              end else begin
                col      <= x_first;
                row      <= row + 8'd1;
                row_base <= row_base + ROW_STEP;
                addr     <= row_base + ROW_STEP + FB_ADDRESS_WIDTH'(x_first);
              end
            end else begin
              col  <= col + 8'd1;
              addr <= addr + FB_ADDRESS_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe follows fb_stall in the same cycle so a stalled cycle never writes
  assign bus.write_fb         = (state == S_DRAW) && !bus.fb_stall;
  assign bus.fb_address_write = addr;
  assign bus.fb_data_in       = data;
  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed and randomized commands against a pixel-list reference model;
// write order, data, write cycles and done timing are all checked.
module tb_fb_fill_engine;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int   wr_addr[$];
  int   wr_data[$];
  int   wr_k[$];
  int   exp_addr[$];
  int   exp_k[$];
  bit   stalled[$];

  fb_fill_engine_if bus ();

  fb_fill_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Reference: enumerate every pixel of the effective rectangle, keep those on screen
  function automatic void build_expect(input int op, input int x, input int y, input int w, input int h);
    int ex, ey, ew, eh;
    exp_addr.delete();
    ex = x; ey = y; ew = w; eh = h;
    if (op == 0) begin ew = 1; eh = 1; end
    else if (op == 2) begin ex = 0; ey = 0; ew = 160; eh = 120; end
    else if (op == 3) ew = 0;
    for (int r = ey; r < ey + eh; r++)
      for (int c = ex; c < ex + ew; c++)
        if (r < 120 && c < 160) exp_addr.push_back(r * 160 + c);
  endfunction

  // The i-th write lands on the i-th unstalled cycle counted from accept+2
  function automatic int build_cycles();
    int kk = 2;
    exp_k.delete();
    for (int i = 0; i < exp_addr.size(); i++) begin
      while (kk < stalled.size() && stalled[kk]) kk++;
      exp_k.push_back(kk);
      kk++;
    end
    return (exp_addr.size() == 0) ? 2 : exp_k[exp_k.size()-1] + 1;
  endfunction

  // Starts and ends 1 time unit after a rising edge
  task automatic run_cmd(input string tag, input int op, input int x, input int y, input int w,
                         input int h, input int color, input int stall_mode, input int abort_at);
    int done_k, exp_done, n, e0, idle_busy, stray;
    bit aborted;
    build_expect(op, x, y, w, h);
    wr_addr.delete(); wr_data.delete(); wr_k.delete(); stalled.delete();
    bus.cmd_op    = 2'(op);
    bus.cmd_x     = 8'(x);
    bus.cmd_y     = 8'(y);
    bus.cmd_w     = 8'(w);
    bus.cmd_h     = 8'(h);
    bus.cmd_color = 8'(color);
    bus.cmd_valid = 1'b1;
    bus.fb_stall  = 1'b0;
    stalled.push_back(1'b0);
    @(negedge clk);
    check({tag, " ready_at_accept"}, bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_x     = 8'($urandom);
    bus.cmd_y     = 8'($urandom);
    bus.cmd_w     = 8'($urandom);
    bus.cmd_h     = 8'($urandom);
    bus.cmd_color = 8'($urandom);
    done_k = -1; aborted = 1'b0; idle_busy = 0;
    for (int k = 1; k <= 25000; k++) begin
      case (stall_mode)
        1:       bus.fb_stall = 1'($urandom_range(0, 1));
        2:       bus.fb_stall = (k >= 2 && k <= 4);
        default: bus.fb_stall = 1'b0;
      endcase
      stalled.push_back(bus.fb_stall);
      @(negedge clk);
      if (k == 1) check({tag, " ready_low_setup"}, bus.cmd_ready, 0);
      if (bus.busy !== 1'b1) idle_busy++;
      if (bus.write_fb) begin
        wr_addr.push_back(int'(bus.fb_address_write));
        wr_data.push_back(int'(bus.fb_data_in));
        wr_k.push_back(k);
      end
      if (bus.done) done_k = k;
      if (abort_at > 0 && wr_addr.size() == abort_at) begin
        reset = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      bus.fb_stall = 1'b0;
      if (aborted) begin
        reset = 1'b0;
        break;
      end
      if (done_k >= 0) break;
    end
    if (aborted) begin
      @(negedge clk);
      check({tag, " write_after_reset"}, bus.write_fb, 0);
      check({tag, " done_after_reset"}, bus.done, 0);
      check({tag, " ready_after_reset"}, bus.cmd_ready, 1);
      check({tag, " busy_after_reset"}, bus.busy, 0);
      stray = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.done !== 1'b0 || bus.write_fb !== 1'b0) stray++;
      end
      check({tag, " quiet_after_reset"}, stray, 0);
      @(posedge clk); #1;
      return;
    end
    if (done_k < 0) begin
      check({tag, " done_seen"}, 0, 1);
      finish_run();
    end
    exp_done = build_cycles();
    check({tag, " busy_until_done"}, idle_busy, 0);
    check({tag, " write_count"}, wr_addr.size(), exp_addr.size());
    check({tag, " done_cycle"}, done_k, exp_done);
    n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      e0 = errors;
      check($sformatf("%s addr[%0d]", tag, i), wr_addr[i], exp_addr[i]);
      check($sformatf("%s data[%0d]", tag, i), wr_data[i], color & 8'hFF);
      check($sformatf("%s cycle[%0d]", tag, i), wr_k[i], exp_k[i]);
      if (errors != e0) break;
    end
    @(negedge clk);
    check({tag, " done_width"}, bus.done, 0);
    check({tag, " ready_after_done"}, bus.cmd_ready, 1);
    check({tag, " idle_busy"}, bus.busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int op_r, r;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
    bus.cmd_color = '0;
    bus.fb_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset write_fb", bus.write_fb, 0);
    check("reset done", bus.done, 0);
    check("reset busy", bus.busy, 0);
    check("reset cmd_ready", bus.cmd_ready, 1);
    check("reset address", bus.fb_address_write, 0);
    check("reset data", bus.fb_data_in, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_cmd("small_rect", 1, 10, 2, 3, 2, 8'h5A, 0, 0);
    run_cmd("clip_br", 1, 158, 119, 5, 5, 8'h11, 0, 0);
    run_cmd("empty_x", 1, 200, 0, 4, 4, 8'h22, 0, 0);
    run_cmd("empty_w", 1, 5, 5, 0, 4, 8'h23, 0, 0);
    run_cmd("op3", 3, 5, 5, 4, 4, 8'h24, 0, 0);
    run_cmd("stall_plot", 0, 0, 0, 7, 9, 8'hFF, 2, 0);
    run_cmd("stall_rect", 1, 20, 30, 4, 4, 8'h3C, 1, 0);
    run_cmd("clear", 2, 40, 50, 3, 3, 8'h00, 0, 0);

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 3);
      op_r = (r == 0) ? 0 : (r == 3) ? 3 : 1;
      run_cmd($sformatf("rand%0d", i), op_r, $urandom_range(0, 170), $urandom_range(0, 130),
              $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 255),
              $urandom_range(0, 1), 0);
    end

    run_cmd("reset_clear", 2, 0, 0, 0, 0, 8'h33, 0, 50);
    run_cmd("plot_after_reset", 0, 1, 1, 0, 0, 8'h44, 0, 0);
    check("plot_after_reset addr161", (wr_addr.size() > 0) ? wr_addr[0] : -1, 161);

    finish_run();
  end

endmodule
